// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared AES datapath constants, round-back-end FSM states, helpers
// Revision: 1.0
// ============================================================================
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;
    localparam int AES_NCOL    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mak_state_t;

    // Column 0 occupies the most significant word of the state.
    function automatic logic [AES_COL_W-1:0] col_sel(
        input logic [AES_STATE_W-1:0] s,
        input logic [1:0]             idx
    );
        logic [AES_COL_W-1:0] c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic logic [AES_STATE_W-1:0] col_put(
        input logic [AES_STATE_W-1:0] s,
        input logic [1:0]             idx,
        input logic [AES_COL_W-1:0]   c
    );
        logic [AES_STATE_W-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_addkey_seq_mixcolum.sv
`default_nettype none
// ============================================================================
// mixcolum : combinational AES MixColumns on one 32-bit column (byte 0 = MSB)
// Revision: 1.0
// ============================================================================
module mixcolum
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] b  [4];
    logic [7:0] xt [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign b[i]  = col_in[31-8*i -: 8];
        // Multiply by x modulo x^8+x^4+x^3+x+1.
        assign xt[i] = {b[i][6:0], 1'b0} ^ (b[i][7] ? 8'h1b : 8'h00);
    end

    assign col_out[31:24] = xt[0] ^ xt[1] ^ b[1] ^ b[2] ^ b[3];
    assign col_out[23:16] = b[0] ^ xt[1] ^ xt[2] ^ b[2] ^ b[3];
    assign col_out[15:8]  = b[0] ^ b[1] ^ xt[2] ^ xt[3] ^ b[3];
    assign col_out[7:0]   = xt[0] ^ b[0] ^ b[1] ^ b[2] ^ xt[3];

endmodule
`default_nettype wire

// File: rtl/mix_addkey_seq.sv
`default_nettype none
// ============================================================================
// mix_addkey_seq : column-serial MixColumns + AddRoundKey AES round back end
// Revision: 1.0
// ============================================================================
module mix_addkey_seq
    import aes_pkg::*;
#(
    parameter bit LAST_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic [AES_STATE_W-1:0] in_key,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    mak_state_t             state_q;
    mak_state_t             state_d;
    logic [1:0]             col_q;
    logic [AES_STATE_W-1:0] blk_q;
    logic [AES_STATE_W-1:0] key_q;
    logic                   last_q;
    logic [AES_STATE_W-1:0] out_q;

    logic [AES_COL_W-1:0]   mix_in;
    logic [AES_COL_W-1:0]   mix_out;
    logic [AES_COL_W-1:0]   res_col;
    logic                   accept;
    logic                   last_col;

    assign mix_in   = col_sel(blk_q, col_q);
    assign res_col  = (last_q ? mix_in : mix_out) ^ col_sel(key_q, col_q);
    assign accept   = (state_q == IDLE) && in_valid;
    assign last_col = (col_q == 2'(AES_NCOL - 1));

    mixcolum u_mixcolum (
        .col_in  (mix_in),
        .col_out (mix_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_col) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= 2'd0;
            blk_q  <= '0;
            key_q  <= '0;
            last_q <= 1'b0;
            out_q  <= '0;
        end else if (accept) begin
            col_q  <= 2'd0;
            blk_q  <= in_state;
            key_q  <= in_key;
            last_q <= LAST_EN ? in_last : 1'b0;
        end else if (state_q == BUSY) begin
            out_q <= col_put(out_q, col_q, res_col);
            col_q <= col_q + 2'd1;
        end
    end

    assign out_state = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_addkey_seq.sv
`default_nettype none
// ============================================================================
// tb_mix_addkey_seq : randomized self-checking bench against a GF(2^8) model
// Revision: 1.0
// ============================================================================
module tb_mix_addkey_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_ready0;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_valid0;
    logic         out_ready;
    logic [127:0] out_state;
    logic [127:0] out_state0;

    int n_checks;
    int n_errors;

    mix_addkey_seq #(.LAST_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_key(in_key), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
    );

    mix_addkey_seq #(.LAST_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_state(in_state), .in_key(in_key), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_state(out_state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Full carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({7'b0, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic l);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        logic [127:0] o;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        o = s;
        if (!l) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
                for (int i = 0; i < 4; i++) begin
                    r = 8'h00;
                    for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - i + 4) % 4], a[j]);
                    o[127 - 32*c - 8*i -: 8] = r;
                end
            end
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", {127'b0, in_ready}, 128'd1);
        in_state = s; in_key = k; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, 128'(lat), 128'd4);
        chk({tag, "_v0"}, {127'b0, out_valid0}, 128'd1);
    endtask

    task automatic recv();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic block(input string tag, input logic [127:0] s, input logic [127:0] k,
                         input logic l);
        send(s, k, l);
        wait_out({tag, "_lat"});
        chk({tag, "_d1"}, out_state, ref_round(s, k, l));
        chk({tag, "_d0"}, out_state0, ref_round(s, k, 1'b0));
        recv();
    endtask

    localparam logic [127:0] TV_S = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    initial begin
        logic [127:0] s, k, s2, k2, e, e0;
        logic         l, l2;
        logic [127:0] q1 [$];
        logic [127:0] q0 [$];
        int           acc [$];
        int           idx, cyc, stall;

        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

        // Known-answer vectors.
        send(TV_S, 128'd0, 1'b0);
        wait_out("kat_mix_lat");
        chk("kat_mix", out_state, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        chk("kat_mix0", out_state0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        recv();
        chk("kat_post_ready", {127'b0, in_ready}, 128'd1);
        send(TV_S, {128{1'b1}}, 1'b1);
        wait_out("kat_last_lat");
        chk("kat_last", out_state, 128'h24ecacba_0df5dda3_fefefefe_39393939);
        chk("kat_last_en0", out_state0, 128'h71b25e43_6023a762_fefefefe_39393939);
        recv();

        // Output stall with a second block waiting upstream.
        s = rnd128(); k = rnd128(); l = 1'b0;
        s2 = rnd128(); k2 = rnd128(); l2 = 1'b1;
        send(s, k, l);
        wait_out("bp_lat");
        e = ref_round(s, k, l);
        in_state = s2; in_key = k2; in_last = l2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_state", out_state, e);
            chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_hs_valid", {127'b0, out_valid}, 128'd0);
        chk("bp_after_hs_ready", {127'b0, in_ready}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_taken", {127'b0, in_ready}, 128'd0);
        wait_out("bp2_lat");
        chk("bp2_d1", out_state, ref_round(s2, k2, l2));
        chk("bp2_d0", out_state0, ref_round(s2, k2, 1'b0));
        recv();

        // Back-to-back with in_valid held high and downstream always ready.
        out_ready = 1'b1;
        idx = 0; cyc = 0;
        while ((idx < 3 || q1.size() > 0) && cyc < 100) begin
            if (out_valid) begin
                if (q1.size() > 0) begin
                    e = q1.pop_front(); e0 = q0.pop_front();
                    chk("b2b_d1", out_state, e);
                    chk("b2b_d0", out_state0, e0);
                end else begin
                    chk("b2b_spurious", {127'b0, out_valid}, 128'd0);
                end
            end
            if (in_ready && idx < 3) begin
                s = rnd128(); k = rnd128(); l = 1'($urandom_range(0, 1));
                in_state = s; in_key = k; in_last = l; in_valid = 1'b1;
                q1.push_back(ref_round(s, k, l));
                q0.push_back(ref_round(s, k, 1'b0));
                acc.push_back(cyc);
                idx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_drained", 128'(q1.size()), 128'd0);
        chk("b2b_count", 128'(acc.size()), 128'd3);
        if (acc.size() == 3) begin
            chk("b2b_gap01", 128'(acc[1] - acc[0]), 128'd6);
            chk("b2b_gap12", 128'(acc[2] - acc[1]), 128'd6);
        end

        // Reset two cycles into a block.
        send(rnd128(), rnd128(), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {127'b0, out_valid}, 128'd0);
        chk("mid_rst_state", out_state, 128'd0);
        chk("mid_rst_ready", {127'b0, in_ready}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rel_ready", {127'b0, in_ready}, 128'd1);
        repeat (6) @(negedge clk);
        chk("mid_rst_no_residue", {127'b0, out_valid}, 128'd0);
        chk("mid_rst_state_hold", out_state, 128'd0);
        block("fresh", rnd128(), rnd128(), 1'b0);

        // Random blocks with random output stalls.
        for (int n = 0; n < 12; n++) begin
            s = rnd128(); k = rnd128(); l = 1'($urandom_range(0, 1));
            send(s, k, l);
            wait_out("rnd_lat");
            e = ref_round(s, k, l);
            stall = $urandom_range(0, 3);
            for (int j = 0; j <= stall; j++) begin
                chk("rnd_d1", out_state, e);
                chk("rnd_d0", out_state0, ref_round(s, k, 1'b0));
                chk("rnd_valid", {127'b0, out_valid}, 128'd1);
                @(negedge clk);
            end
            recv();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
